// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-word sequencer driving a shared 8-bit ALU, LS word first
module alu_seq_ctrl #(
    parameter int DataWidth = 8,
    parameter int Words     = 4,
    parameter int LenWidth  = 3,
    parameter int FlagBits  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [3:0]                 i_op,
    input  logic [LenWidth-1:0]        i_len,
    input  logic                       i_carry_in,
    input  logic [DataWidth*Words-1:0] i_op_a,
    input  logic [DataWidth*Words-1:0] i_op_b,
    output logic [DataWidth-1:0]       o_alu_a,
    output logic [DataWidth-1:0]       o_alu_b,
    output logic [3:0]                 o_alu_op,
    output logic [FlagBits-1:0]        o_alu_iflags,
    input  logic [DataWidth-1:0]       i_alu_y,
    input  logic [FlagBits-1:0]        i_alu_oflags,
    output logic [DataWidth*Words-1:0] o_result,
    output logic [FlagBits-1:0]        o_flags,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [DataWidth*Words-1:0]   r_a;
    logic [DataWidth*Words-1:0]   r_b;
    logic [DataWidth*Words-1:0]   r_result;
    logic [3:0]                   r_op;
    logic [LenWidth-1:0]          r_len;
    logic [LenWidth-1:0]          r_idx;
    logic                         r_carry;
    logic                         r_zacc;
    logic [FlagBits-1:0]          r_flags;
    logic                         r_done;
    logic                         r_error;

    logic [DataWidth-1:0]         w_a_word;
    logic [DataWidth-1:0]         w_b_word;
    logic                         w_legal;
    logic                         w_is_arith;
    logic                         w_last;

    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < Words; i++) begin
            if (r_idx == LenWidth'(i)) begin
                w_a_word = r_a[i*DataWidth +: DataWidth];
                w_b_word = r_b[i*DataWidth +: DataWidth];
            end
        end
    end

    assign w_legal    = (i_op <= OP_XOR) && (i_len != '0) && (i_len <= LenWidth'(Words));
    assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_last     = (r_idx == r_len - LenWidth'(1));

    // Subtract runs through the adder as A + ~B + 1; the +1 is the initial carry.
    always_comb begin
        w_state_nxt  = r_state;
        o_alu_a      = '0;
        o_alu_b      = '0;
        o_alu_op     = OP_ADD;
        o_alu_iflags = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start && w_legal) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                o_alu_a         = w_a_word;
                o_alu_b         = (r_op == OP_SUB) ? ~w_b_word : w_b_word;
                o_alu_op        = w_is_arith ? OP_ADD : r_op;
                o_alu_iflags[1] = r_carry;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_legal) begin
                        r_a      <= i_op_a;
                        r_b      <= i_op_b;
                        r_op     <= i_op;
                        r_len    <= i_len;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_zacc   <= 1'b1;
                        r_carry  <= (i_op == OP_ADD) ? i_carry_in : (i_op == OP_SUB);
                    end else if (i_start) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end
                end
                S_EXEC: begin
                    for (int i = 0; i < Words; i++) begin
                        if (r_idx == LenWidth'(i)) begin
                            r_result[i*DataWidth +: DataWidth] <= i_alu_y;
                        end
                    end
                    r_carry <= w_is_arith & i_alu_oflags[1];
                    r_zacc  <= r_zacc & i_alu_oflags[0];
                    r_idx   <= r_idx + LenWidth'(1);
                    if (w_last) begin
                        r_flags <= {i_alu_oflags[3], i_alu_oflags[2],
                                    w_is_arith & i_alu_oflags[1], r_zacc & i_alu_oflags[0]};
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result = r_result;
    assign o_flags  = r_flags;
    assign o_busy   = (r_state == S_EXEC);
    assign o_done   = r_done;
    assign o_error  = r_error;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and randomized bench for alu_seq_ctrl with an 8-bit ALU model
module tb_alu_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [2:0]  len;
    logic        cin;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [3:0]  alu_if;
    logic [7:0]  alu_y;
    logic [3:0]  alu_of;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_len(len),
        .i_carry_in(cin), .i_op_a(op_a), .i_op_b(op_b),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_iflags(alu_if),
        .i_alu_y(alu_y), .i_alu_oflags(alu_of),
        .o_result(result), .o_flags(flags), .o_busy(busy), .o_done(done), .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 8-bit ALU: flags {V,N,C,Z}; logic ops report V=0, C=0.
    logic [8:0] sum9;
    always_comb begin
        sum9   = '0;
        alu_y  = '0;
        alu_of = '0;
        case (alu_op)
            4'd0: begin
                sum9      = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_if[1]};
                alu_y     = sum9[7:0];
                alu_of[1] = sum9[8];
                alu_of[3] = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            4'd2: alu_y = alu_a & alu_b;
            4'd3: alu_y = alu_a | alu_b;
            4'd4: alu_y = alu_a ^ alu_b;
            default: alu_y = '0;
        endcase
        alu_of[2] = alu_y[7];
        alu_of[0] = (alu_y == 8'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-operand arithmetic on Len*8 bits; returns {V,N,C,Z,result}.
    function automatic logic [35:0] ref_model(input logic [3:0] f, input int n_words,
                                              input logic c_in, input logic [31:0] a,
                                              input logic [31:0] b);
        longint unsigned mod, am, bm, r;
        longint sa, sb, ss, half;
        logic v, c, n, z;
        mod  = 64'd1 << (8 * n_words);
        half = longint'(mod / 2);
        am   = a % mod;
        bm   = b % mod;
        sa   = (am >= mod / 2) ? longint'(am) - longint'(mod) : longint'(am);
        sb   = (bm >= mod / 2) ? longint'(bm) - longint'(mod) : longint'(bm);
        v = 1'b0;
        c = 1'b0;
        ss = 0;
        case (f)
            4'd0: begin
                r  = am + bm + longint'(c_in);
                c  = (r >= mod);
                r  = r % mod;
                ss = sa + sb + longint'(c_in);
                v  = (ss >= half) || (ss < -half);
            end
            4'd1: begin
                r  = (am + mod - bm) % mod;
                c  = (am >= bm);
                ss = sa - sb;
                v  = (ss >= half) || (ss < -half);
            end
            4'd2: r = am & bm;
            4'd3: r = am | bm;
            4'd4: r = am ^ bm;
            default: r = 0;
        endcase
        n = (r >= mod / 2);
        z = (r == 0);
        return {v, n, c, z, 32'(r)};
    endfunction

    task automatic issue(input logic [3:0] f, input logic [2:0] l, input logic c_in,
                         input logic [31:0] a, input logic [31:0] b);
        op    = f;
        len   = l;
        cin   = c_in;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        op    = 4'($urandom_range(0, 4));
        cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_op(input string tag, input int exp_busy, input logic [31:0] exp_res,
                             input logic [3:0] exp_fl);
        bit found;
        int busy_cnt;
        found    = 0;
        busy_cnt = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            chk({tag, " aluop"}, 64'(alu_op inside {4'd0, 4'd2, 4'd3, 4'd4}), 64'd1);
            if (done) found = 1;
            else if (busy) busy_cnt++;
        end
        chk({tag, " done"}, 64'(found), 64'd1);
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({tag, " result"}, 64'(result), 64'(exp_res));
        chk({tag, " flags"}, 64'(flags), 64'(exp_fl));
        chk({tag, " error"}, 64'(error), 64'd0);
    endtask

    task automatic illegal(input string tag, input logic [3:0] f, input logic [2:0] l,
                           input logic [31:0] hold_res, input logic [3:0] hold_fl);
        issue(f, l, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " error"}, 64'(error), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " result hold"}, 64'(result), 64'(hold_res));
        chk({tag, " flags hold"}, 64'(flags), 64'(hold_fl));
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, 64'(done), 64'd0);
        chk({tag, " error pulse"}, 64'(error), 64'd0);
        chk({tag, " stays idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [35:0] m;
        logic [3:0]  rf;
        logic [2:0]  rl;
        logic        rc;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        len   = '0;
        cin   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #3;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset error", 64'(error), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset flags", 64'(flags), 64'd0);
        chk("reset aluop", 64'(alu_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd0, 3'd4, 1'b0, 32'h00FF_FFFF, 32'h0000_0001);
        finish_op("add4", 4, 32'h0100_0000, 4'b0000);

        issue(4'd1, 3'd4, 1'b0, 32'h0000_0000, 32'h0000_0001);
        chk("sub w0 aluop", 64'(alu_op), 64'd0);
        chk("sub w0 alub", 64'(alu_b), 64'hFE);
        chk("sub w0 carry in", 64'(alu_if), 64'b0010);
        finish_op("sub4", 4, 32'hFFFF_FFFF, 4'b0100);

        issue(4'd0, 3'd2, 1'b0, 32'hABCD_7FFF, 32'h5555_0001);
        finish_op("ovf2", 2, 32'h0000_8000, 4'b1100);

        illegal("ill op7", 4'd7, 3'd2, 32'h0000_8000, 4'b1100);
        illegal("ill len0", 4'd0, 3'd0, 32'h0000_8000, 4'b1100);
        illegal("ill len5", 4'd2, 3'd5, 32'h0000_8000, 4'b1100);

        issue(4'd0, 3'd1, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        finish_op("add1 zc", 1, 32'h0000_0000, 4'b0011);
        issue(4'd4, 3'd3, 1'b0, 32'h0012_3456, 32'h0012_3456);
        finish_op("xor3 b2b", 3, 32'h0000_0000, 4'b0001);

        issue(4'd0, 3'd4, 1'b1, 32'h1111_1111, 32'h2222_2222);
        start = 1'b1;
        op    = 4'd1;
        len   = 3'd1;
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'h0000_0001;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        finish_op("start ignored", 2, 32'h3333_3334, 4'b0000);

        for (int k = 0; k < 40; k++) begin
            rf = 4'($urandom_range(0, 4));
            rl = 3'($urandom_range(1, 4));
            rc = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (k % 8 == 0) ? ra : $urandom;
            m  = ref_model(rf, int'(rl), rc, ra, rb);
            issue(rf, rl, rc, ra, rb);
            finish_op($sformatf("rand%0d op%0d len%0d", k, rf, rl), int'(rl), m[31:0], m[35:32]);
        end

        issue(4'd0, 3'd4, 1'b0, 32'h0102_0304, 32'h1010_1010);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post-abort no done", 64'(done), 64'd0);
        end
        issue(4'd0, 3'd3, 1'b1, 32'h00FF_FFFF, 32'h0000_0001);
        finish_op("after reset", 3, 32'h0000_0001, 4'b0010);
        @(negedge clk);
        chk("done one cycle", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
